// File: rtl/shift_rotate_sequencer_if.sv
// Purpose: handshake/data bundle between the control unit and the shift/rotate sequencer.
// Latency: n/a (wires only).
// Backpressure: the master must hold off issuing while busy; start is ignored in RUN.
// Ports (master view): start, op[2:0], A, B, kill out; busy, done, R in.
interface shift_rotate_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             kill;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;

    modport master (
        output start, op, A, B, kill,
        input  busy, done, R
    );

    modport slave (
        input  start, op, A, B, kill,
        output busy, done, R
    );
endinterface

// File: rtl/shift_rotate_sequencer.sv
// Purpose: multi-cycle SHR/SHRA/SHL/ROR/ROL of A by (B mod WIDTH), one bit position per clock.
// Latency: done is high in the cycle after accept edge t0 + M (M = 0..WIDTH-1).
// Backpressure: busy while running; start is only taken in IDLE/DONE, kill aborts at any edge.
// Ports: clock, reset (sync, active-high), sr (slave modport: start/op/A/B/kill in, busy/done/R out).
module shift_rotate_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    shift_rotate_sequencer_if.slave sr
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    logic [1:0]         state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   step;
    logic [SHAMT_W-1:0] amount;
    logic               pass_through;

    // Only the low SHAMT_W bits of B form the amount; the rest are don't-care.
    logic unused_b_hi;
    assign unused_b_hi = ^sr.B[WIDTH-1:SHAMT_W];

    assign amount       = sr.B[SHAMT_W-1:0];
    // Zero amount or an undefined opcode completes immediately with A unchanged.
    assign pass_through = (amount == '0) || (sr.op > OP_ROL);

    // One-bit step of the captured operation applied to the work register.
    always_comb begin
        step = work;
        case (op_q)
            OP_SHR:  step = {1'b0, work[WIDTH-1:1]};
            OP_SHRA: step = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_SHL:  step = {work[WIDTH-2:0], 1'b0};
            OP_ROR:  step = {work[0], work[WIDTH-1:1]};
            OP_ROL:  step = {work[WIDTH-2:0], work[WIDTH-1]};
            default: step = work;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            work  <= '0;
            cnt   <= '0;
            op_q  <= '0;
            r_q   <= '0;
        end else if (sr.kill) begin
            // Abort: drop whatever is in flight, keep the last published result.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (sr.start) begin
                        work <= sr.A;
                        cnt  <= amount;
                        op_q <= sr.op;
                        if (pass_through) begin
                            state <= S_DONE;
                            r_q   <= sr.A;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    work <= step;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state <= S_DONE;
                        r_q   <= step;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sr.busy = (state == S_RUN);
    assign sr.done = (state == S_DONE);
    assign sr.R    = r_q;
endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Purpose: directed self-checking bench for shift_rotate_sequencer.
// Latency: checks done timing relative to the accept edge for each operation.
// Backpressure: exercises start-while-busy, back-to-back accept, kill and mid-op reset.
module tb_shift_rotate_sequencer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    shift_rotate_sequencer_if #(.WIDTH(32)) sr_if ();

    shift_rotate_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .sr    (sr_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one request, then waits (bounded) for done. Called #1 after a rising edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc);
        sr_if.start = 1'b1;
        sr_if.op    = o;
        sr_if.A     = a;
        sr_if.B     = b;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        lat = 0;
        bc  = 0;
        while (sr_if.done !== 1'b1 && lat < 40) begin
            if (sr_if.busy === 1'b1) bc++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_r);
        int lat, bc;
        run_op(o, a, b, lat, bc);
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (sr_if.R !== exp_r) begin
            failures++;
            $display("FAIL %s result: got %h expected %h", name, sr_if.R, exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (sr_if.busy !== 1'b0 || sr_if.done !== 1'b0 || sr_if.R !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b R=%h expected 0 0 00000000",
                     sr_if.busy, sr_if.done, sr_if.R);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_rol_single();
        int lat, bc;
        run_op(3'b100, 32'h8000_0001, 32'd1, lat, bc);
        checks++;
        if (lat !== 1 || sr_if.R !== 32'h0000_0003) begin
            failures++;
            $display("FAIL rol1: lat=%0d R=%h expected 1 00000003", lat, sr_if.R);
        end
        checks++;
        if (bc !== 1) begin
            failures++;
            $display("FAIL rol1_busy_cycles: got %0d expected 1", bc);
        end
        @(posedge clock); #1;
        checks++;
        if (sr_if.done !== 1'b0 || sr_if.R !== 32'h0000_0003) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b R=%h expected 0 00000003", sr_if.done, sr_if.R);
        end
    endtask

    task automatic test_shifts();
        check_op("ror4",    3'b011, 32'h0000_0001, 32'd4,  4,  32'h1000_0000);
        check_op("shl31",   3'b010, 32'h0000_0001, 32'd31, 31, 32'h8000_0000);
        check_op("shra31",  3'b001, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF);
        check_op("shr31",   3'b000, 32'h8000_0000, 32'd31, 31, 32'h0000_0001);
        check_op("shra_pos",3'b001, 32'h4000_0000, 32'd2,  2,  32'h1000_0000);
        check_op("rol_b33", 3'b100, 32'h8000_0001, 32'd33, 1,  32'h0000_0003);
    endtask

    task automatic test_zero_amount();
        int lat, bc;
        run_op(3'b100, 32'hDEAD_BEEF, 32'd32, lat, bc);
        checks++;
        if (lat !== 0 || sr_if.R !== 32'hDEAD_BEEF || bc !== 0) begin
            failures++;
            $display("FAIL zero_amount: lat=%0d R=%h busy_cycles=%0d expected 0 deadbeef 0",
                     lat, sr_if.R, bc);
        end
        run_op(3'b110, 32'h1234_5678, 32'd7, lat, bc);
        checks++;
        if (lat !== 0 || sr_if.R !== 32'h1234_5678 || bc !== 0) begin
            failures++;
            $display("FAIL pass_op: lat=%0d R=%h busy_cycles=%0d expected 0 12345678 0",
                     lat, sr_if.R, bc);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_start_ignored();
        int lat;
        sr_if.start = 1'b1;
        sr_if.op    = 3'b100;
        sr_if.A     = 32'h0000_0001;
        sr_if.B     = 32'd8;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        lat = 0;
        while (sr_if.done !== 1'b1 && lat < 40) begin
            if (lat == 3) begin
                sr_if.start = 1'b1;
                sr_if.A     = 32'h0000_000F;
                sr_if.B     = 32'd1;
            end else begin
                sr_if.start = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
        end
        sr_if.start = 1'b0;
        checks++;
        if (lat !== 8 || sr_if.R !== 32'h0000_0100) begin
            failures++;
            $display("FAIL start_in_run: lat=%0d R=%h expected 8 00000100", lat, sr_if.R);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(3'b100, 32'h0000_0001, 32'd1, lat, bc);
        // Still in DONE: a zero-amount request keeps done high with the new result.
        sr_if.start = 1'b1;
        sr_if.op    = 3'b010;
        sr_if.A     = 32'h0000_0005;
        sr_if.B     = 32'd0;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        checks++;
        if (sr_if.done !== 1'b1 || sr_if.R !== 32'h0000_0005) begin
            failures++;
            $display("FAIL b2b_zero: done=%b R=%h expected 1 00000005", sr_if.done, sr_if.R);
        end
        // Accept a multi-cycle op from DONE: done must drop while it runs.
        sr_if.start = 1'b1;
        sr_if.op    = 3'b000;
        sr_if.A     = 32'h0000_0100;
        sr_if.B     = 32'd2;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        checks++;
        if (sr_if.done !== 1'b0 || sr_if.busy !== 1'b1 || sr_if.R !== 32'h0000_0005) begin
            failures++;
            $display("FAIL b2b_run: done=%b busy=%b R=%h expected 0 1 00000005",
                     sr_if.done, sr_if.busy, sr_if.R);
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (sr_if.done !== 1'b1 || sr_if.R !== 32'h0000_0040) begin
            failures++;
            $display("FAIL b2b_result: done=%b R=%h expected 1 00000040", sr_if.done, sr_if.R);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_kill_and_reset();
        int lat, bc, seen;
        run_op(3'b100, 32'h0000_00A5, 32'd0, lat, bc);
        @(posedge clock); #1;
        // Kill mid-run: result discarded, R keeps the previous value.
        sr_if.start = 1'b1;
        sr_if.op    = 3'b011;
        sr_if.A     = 32'h0000_0001;
        sr_if.B     = 32'd16;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        sr_if.kill = 1'b1;
        @(posedge clock); #1;
        sr_if.kill = 1'b0;
        checks++;
        if (sr_if.busy !== 1'b0 || sr_if.done !== 1'b0 || sr_if.R !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL kill: busy=%b done=%b R=%h expected 0 0 000000a5",
                     sr_if.busy, sr_if.done, sr_if.R);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (sr_if.done === 1'b1 || sr_if.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || sr_if.R !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL kill_quiet: activity_cycles=%0d R=%h expected 0 000000a5", seen, sr_if.R);
        end
        // Kill beats start in IDLE.
        sr_if.start = 1'b1;
        sr_if.kill  = 1'b1;
        sr_if.op    = 3'b110;
        sr_if.A     = 32'h5555_5555;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        sr_if.kill  = 1'b0;
        checks++;
        if (sr_if.done !== 1'b0 || sr_if.R !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL kill_priority: done=%b R=%h expected 0 000000a5", sr_if.done, sr_if.R);
        end
        // Reset mid-run: R clears, no done pulse.
        sr_if.start = 1'b1;
        sr_if.op    = 3'b011;
        sr_if.A     = 32'h0000_0001;
        sr_if.B     = 32'd16;
        @(posedge clock); #1;
        sr_if.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (sr_if.busy !== 1'b0 || sr_if.done !== 1'b0 || sr_if.R !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b done=%b R=%h expected 0 0 00000000",
                     sr_if.busy, sr_if.done, sr_if.R);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (sr_if.done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || sr_if.R !== 32'h0) begin
            failures++;
            $display("FAIL reset_quiet: done_cycles=%0d R=%h expected 0 00000000", seen, sr_if.R);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        sr_if.start = 1'b0;
        sr_if.op    = 3'b000;
        sr_if.A     = 32'h0;
        sr_if.B     = 32'h0;
        sr_if.kill  = 1'b0;
        test_reset();
        test_rol_single();
        test_shifts();
        test_zero_amount();
        test_start_ignored();
        test_back_to_back();
        test_kill_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
